// File: rtl/mor1kx_branch_resolver.sv
// Branch resolution for the gshare predictor: queues decoded conditional branch
// predictions, checks them against the real flag and produces update/redirect.
module mor1kx_branch_resolver #(
  parameter int QUEUE_DEPTH          = 4,
  parameter int OPTION_OPERAND_WIDTH = 32,
  parameter int CNT_WIDTH            = 16
) (
  input  logic                            clk,
  input  logic                            rst,
  input  logic                            padv_decode_i,
  input  logic                            decode_op_bf_i,
  input  logic                            decode_op_bnf_i,
  input  logic                            predicted_flag_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] decode_pc_i,
  input  logic [OPTION_OPERAND_WIDTH-1:0] decode_target_i,
  input  logic                            resolve_valid_i,
  input  logic                            flag_i,
  input  logic                            pipeline_flush_i,
  output logic                            queue_full_o,
  output logic                            queue_empty_o,
  output logic                            upd_valid_o,
  output logic                            upd_taken_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] upd_pc_o,
  output logic                            branch_mispredict_o,
  output logic [OPTION_OPERAND_WIDTH-1:0] redirect_pc_o,
  output logic                            protocol_error_o,
  output logic [CNT_WIDTH-1:0]            branch_count_o,
  output logic [CNT_WIDTH-1:0]            mispredict_count_o
);
  localparam int PTR_W = $clog2(QUEUE_DEPTH);
  localparam int CQ_W  = PTR_W + 1;

  logic                            r_is_bf [QUEUE_DEPTH];
  logic                            r_pred  [QUEUE_DEPTH];
  logic [OPTION_OPERAND_WIDTH-1:0] r_pc    [QUEUE_DEPTH];
  logic [OPTION_OPERAND_WIDTH-1:0] r_tgt   [QUEUE_DEPTH];
  logic [PTR_W-1:0]                r_rd_ptr, r_wr_ptr;
  logic [CQ_W-1:0]                 r_count;

  logic                            r_upd_valid_p1, r_upd_taken_p1, r_mis_p1, r_perr;
  logic [OPTION_OPERAND_WIDTH-1:0] r_upd_pc_p1, r_redirect_p1;
  logic [CNT_WIDTH-1:0]            r_br_cnt, r_mis_cnt;

  logic                            w_full, w_empty, w_pop, w_mis, w_taken, w_push, w_clear;
  logic [OPTION_OPERAND_WIDTH-1:0] w_redirect;

  function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
    return (&v) ? v : v + CNT_WIDTH'(1);
  endfunction

  // Stage p0: resolve decision against the oldest queued prediction
  assign w_full     = (r_count == CQ_W'(QUEUE_DEPTH));
  assign w_empty    = (r_count == '0);
  assign w_pop      = resolve_valid_i && !w_empty && !pipeline_flush_i;
  assign w_mis      = w_pop && (r_pred[r_rd_ptr] != flag_i);
  assign w_taken    = r_is_bf[r_rd_ptr] ? flag_i : !flag_i;
  assign w_redirect = w_taken ? r_tgt[r_rd_ptr]
                              : r_pc[r_rd_ptr] + OPTION_OPERAND_WIDTH'(8);
  // A mispredict makes every younger entry (and any same-cycle push) wrong-path
  assign w_clear    = pipeline_flush_i || w_mis;
  assign w_push     = padv_decode_i && (decode_op_bf_i || decode_op_bnf_i) &&
                      !w_clear && (!w_full || w_pop);

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_is_bf[r_wr_ptr] <= decode_op_bf_i;
      r_pred[r_wr_ptr]  <= predicted_flag_i;
      r_pc[r_wr_ptr]    <= decode_pc_i;
      r_tgt[r_wr_ptr]   <= decode_target_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst || w_clear) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PTR_W'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CQ_W'(1);
        2'b01:   r_count <= r_count - CQ_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // Stage p1: registered update, redirect and statistics
  always_ff @(posedge clk) begin
    if (rst) begin
      r_upd_valid_p1 <= 1'b0;
      r_upd_taken_p1 <= 1'b0;
      r_upd_pc_p1    <= '0;
      r_mis_p1       <= 1'b0;
      r_redirect_p1  <= '0;
      r_perr         <= 1'b0;
      r_br_cnt       <= '0;
      r_mis_cnt      <= '0;
    end else begin
      r_upd_valid_p1 <= w_pop;
      r_mis_p1       <= w_mis;
      if (w_pop) begin
        r_upd_taken_p1 <= w_taken;
        r_upd_pc_p1    <= r_pc[r_rd_ptr];
        r_redirect_p1  <= w_redirect;
        r_br_cnt       <= sat_inc(r_br_cnt);
      end
      if (w_mis) r_mis_cnt <= sat_inc(r_mis_cnt);
      if (resolve_valid_i && w_empty && !pipeline_flush_i) r_perr <= 1'b1;
    end
  end

  assign queue_full_o        = w_full;
  assign queue_empty_o       = w_empty;
  assign upd_valid_o         = r_upd_valid_p1;
  assign upd_taken_o         = r_upd_taken_p1;
  assign upd_pc_o            = r_upd_pc_p1;
  assign branch_mispredict_o = r_mis_p1;
  assign redirect_pc_o       = r_redirect_p1;
  assign protocol_error_o    = r_perr;
  assign branch_count_o      = r_br_cnt;
  assign mispredict_count_o  = r_mis_cnt;
endmodule

// File: tb/tb_mor1kx_branch_resolver.sv
// Bench for mor1kx_branch_resolver: directed scenarios plus random traffic,
// checked against a queue-based reference model.
module tb_mor1kx_branch_resolver;
  localparam int QD = 4;
  localparam int W  = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst, padv, op_bf, op_bnf, pred, rv, flag, flush;
  logic [W-1:0]  pc, tgt;
  logic          full, empty, uv, ut, mis, perr;
  logic [W-1:0]  upc, rpc;
  logic [CW-1:0] bc, mc;

  mor1kx_branch_resolver #(.QUEUE_DEPTH(QD), .OPTION_OPERAND_WIDTH(W), .CNT_WIDTH(CW)) dut (
    .clk(clk), .rst(rst), .padv_decode_i(padv), .decode_op_bf_i(op_bf),
    .decode_op_bnf_i(op_bnf), .predicted_flag_i(pred), .decode_pc_i(pc),
    .decode_target_i(tgt), .resolve_valid_i(rv), .flag_i(flag),
    .pipeline_flush_i(flush), .queue_full_o(full), .queue_empty_o(empty),
    .upd_valid_o(uv), .upd_taken_o(ut), .upd_pc_o(upc),
    .branch_mispredict_o(mis), .redirect_pc_o(rpc), .protocol_error_o(perr),
    .branch_count_o(bc), .mispredict_count_o(mc));

  always #5 clk = ~clk;

  typedef struct {
    logic         bf;
    logic         pr;
    logic [W-1:0] pc;
    logic [W-1:0] tgt;
  } ent_t;

  ent_t          q[$];
  logic          m_uv, m_ut, m_mis, m_perr;
  logic [W-1:0]  m_upc, m_rpc;
  logic [CW-1:0] m_bc, m_mc;
  int            n_pass = 0, n_total = 0;

  task automatic chk(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
  endtask

  // Reference: apply one clock of the spec's rules to the queue model
  task automatic model_step();
    int   sz;
    ent_t e;
    logic tk, mp;
    sz    = q.size();
    m_uv  = 1'b0;
    m_mis = 1'b0;
    if (rst) begin
      q.delete();
      m_ut = 0; m_upc = 0; m_rpc = 0; m_perr = 0; m_bc = 0; m_mc = 0;
    end else if (flush) begin
      q.delete();
    end else begin
      mp = 1'b0;
      if (rv && sz == 0) m_perr = 1'b1;
      if (rv && sz > 0) begin
        e     = q.pop_front();
        tk    = e.bf ? flag : !flag;
        mp    = (e.pr != flag);
        m_uv  = 1'b1;
        m_ut  = tk;
        m_upc = e.pc;
        m_rpc = tk ? e.tgt : e.pc + 32'd8;
        m_mis = mp;
        if (m_bc != 4'hF) m_bc = m_bc + 4'd1;
        if (mp && m_mc != 4'hF) m_mc = m_mc + 4'd1;
        if (mp) q.delete();
      end
      if (padv && (op_bf || op_bnf) && !mp && (sz < QD || (rv && sz > 0)))
        q.push_back('{op_bf, pred, pc, tgt});
    end
  endtask

  task automatic cyc(input logic i_padv, i_bf, i_bnf, i_pred, input logic [W-1:0] i_pc, i_tgt,
                     input logic i_rv, i_flag, i_flush, i_rst);
    padv = i_padv; op_bf = i_bf; op_bnf = i_bnf; pred = i_pred; pc = i_pc; tgt = i_tgt;
    rv = i_rv; flag = i_flag; flush = i_flush; rst = i_rst;
    model_step();
    @(posedge clk);
    #1;
    chk("upd_valid", uv, m_uv);
    chk("mispredict", mis, m_mis);
    if (m_uv) begin
      chk("upd_taken", ut, m_ut);
      chk("upd_pc", upc, m_upc);
    end
    chk("redirect_pc", rpc, m_rpc);
    chk("queue_full", full, q.size() == QD);
    chk("queue_empty", empty, q.size() == 0);
    chk("protocol_error", perr, m_perr);
    chk("branch_count", bc, m_bc);
    chk("mispredict_count", mc, m_mc);
  endtask

  task automatic push(input logic bf, bnf, p, input logic [W-1:0] a, t);
    cyc(1, bf, bnf, p, a, t, 0, 0, 0, 0);
  endtask
  task automatic resolve(input logic f);
    cyc(0, 0, 0, 0, 0, 0, 1, f, 0, 0);
  endtask
  task automatic idle();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask
  task automatic reset();
    cyc(0, 0, 0, 0, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    logic [CW-1:0] bc_save;
    reset();
    reset();
    chk("rst_empty", empty, 1'b1);
    chk("rst_count", bc, 4'h0);

    push(1, 0, 1, 32'h100, 32'h200);
    resolve(1);
    chk("tp1_valid", uv, 1'b1);
    chk("tp1_taken", ut, 1'b1);
    chk("tp1_pc", upc, 32'h100);
    chk("tp1_mis", mis, 1'b0);
    chk("tp1_redirect", rpc, 32'h200);

    push(1, 0, 0, 32'hFFFF_FFFC, 32'h10);
    resolve(0);
    chk("wrap_redirect", rpc, 32'h4);

    push(0, 1, 1, 32'h40, 32'h80);
    push(1, 0, 0, 32'h50, 32'h90);
    push(1, 1, 1, 32'h60, 32'hA0);
    resolve(0);
    chk("tp2_mis", mis, 1'b1);
    chk("tp2_taken", ut, 1'b1);
    chk("tp2_redirect", rpc, 32'h80);
    chk("tp2_empty", empty, 1'b1);

    for (int i = 0; i < 4; i++) push(1, 0, 1, 32'h1000 + 32'(i) * 4, 32'h2000);
    chk("tp3_full", full, 1'b1);
    push(1, 0, 1, 32'h500, 32'h2000);
    chk("tp3_still_full", full, 1'b1);
    cyc(1, 1, 0, 1, 32'h600, 32'h700, 1, 1, 0, 0);
    chk("tp3_pp_full", full, 1'b1);
    chk("tp3_pp_pc", upc, 32'h1000);
    for (int i = 0; i < 4; i++) resolve(1);
    chk("tp3_last_pc", upc, 32'h600);
    chk("tp3_empty", empty, 1'b1);

    bc_save = bc;
    for (int i = 0; i < 3; i++) push(0, 1, 0, 32'h300 + 32'(i) * 4, 32'h400);
    cyc(0, 0, 0, 0, 0, 0, 1, 1, 1, 0);
    chk("tp4_no_upd", uv, 1'b0);
    chk("tp4_empty", empty, 1'b1);
    chk("tp4_bc", bc, bc_save);

    resolve(1);
    chk("tp5_perr", perr, 1'b1);
    chk("tp5_no_upd", uv, 1'b0);
    idle();
    idle();
    chk("tp5_perr_held", perr, 1'b1);
    reset();
    chk("tp5_perr_clr", perr, 1'b0);

    for (int i = 0; i < 17; i++) begin
      push(1, 0, 1, 32'h800 + 32'(i) * 4, 32'h900);
      resolve(0);
      if (i == 15) begin
        chk("tp6_bc_sat", bc, 4'hF);
        chk("tp6_mc_sat", mc, 4'hF);
      end
    end
    chk("tp6_bc_hold", bc, 4'hF);
    chk("tp6_mc_hold", mc, 4'hF);
    push(1, 0, 1, 32'hA00, 32'hB00);
    push(1, 0, 1, 32'hA04, 32'hB00);
    reset();
    chk("tp6_rst_bc", bc, 4'h0);
    chk("tp6_rst_mc", mc, 4'h0);
    chk("tp6_rst_empty", empty, 1'b1);

    for (int i = 0; i < 1500; i++) begin
      logic p, r;
      p = ($urandom_range(3) != 0);
      r = ($urandom_range(1) != 0);
      cyc(p, 1'($urandom), 1'($urandom), 1'($urandom), $urandom, $urandom,
          r, ($urandom_range(3) == 0) ? 1'($urandom) : pred,
          ($urandom_range(19) == 0), ($urandom_range(199) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
